// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of the unified memory port between the
// instruction-fetch (I) and data (D) requesters, with a per-access timeout.
module mem_port_arbiter #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              TIMEOUT  = 16,
  parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_rdy,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_rdy,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must lie in 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        r_state;
  logic          r_last_d;
  logic          r_own_d;
  logic [7:0]    r_cnt;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_i_rdy;
  logic          r_d_rdy;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_bus_err;

  logic          w_any;
  logic          w_tie;
  logic          w_gnt_d;
  logic          w_done;
  logic [DW-1:0] w_rdata;

  assign w_any   = i_req | d_req;
  assign w_tie   = i_req & d_req;
  // on a tie the requester that did not win the previous tie goes first
  assign w_gnt_d = w_tie ? ~r_last_d : d_req;
  assign w_done  = mem_ack | (r_cnt == CNT_LAST);
  assign w_rdata = mem_ack ? mem_rdata : ERR_DATA;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_last_d    <= 1'b1;
      r_own_d     <= 1'b0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdy     <= 1'b0;
      r_d_rdy     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state  <= ST_BUSY;
            r_own_d  <= w_gnt_d;
            r_cnt    <= '0;
            r_mem_en <= 1'b1;
            if (w_tie) r_last_d <= w_gnt_d;
            if (w_gnt_d) begin
              r_mem_addr  <= d_addr;
              r_mem_we    <= d_we;
              r_mem_wdata <= d_wdata;
            end else begin
              r_mem_addr  <= i_addr;
              r_mem_we    <= 1'b0;
              r_mem_wdata <= '0;
            end
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_done) begin
            r_state  <= ST_RESP;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (!mem_ack) r_bus_err <= 1'b1;
            if (r_own_d) begin
              r_d_rdy   <= 1'b1;
              r_d_rdata <= w_rdata;
            end else begin
              r_i_rdy   <= 1'b1;
              r_i_rdata <= w_rdata;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_i_rdy <= 1'b0;
          r_d_rdy <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign i_rdy     = r_i_rdy;
  assign i_rdata   = r_i_rdata;
  assign d_rdy     = r_d_rdy;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a
// transaction-timeline model checked every cycle plus literal expectations.
module tb_mem_port_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rdy;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rdy;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        bus_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h100) return 32'h8C010004;
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory responder: ack on the ack_k-th cycle of an mem_en window
  int ack_k = 0;
  bit spur = 1'b0;
  int rsp_n = 0;
  always @(posedge clk) begin
    #2;
    if (mem_en === 1'b1) rsp_n++;
    else rsp_n = 0;
    mem_ack = spur | (mem_en === 1'b1 && ack_k > 0 && rsp_n == ack_k);
    if (!mem_ack) mem_rdata = 32'h0;
    else if (mem_en === 1'b1) mem_rdata = memval(mem_addr);
    else mem_rdata = 32'h12345678;
  end

  // grant log taken from the start of each mem_en window
  bit glog[$];
  bit prev_en = 1'b0;
  always @(negedge clk) begin
    if (mem_en === 1'b1 && !prev_en) glog.push_back(mem_addr[13]);
    prev_en = (mem_en === 1'b1);
  end

  // model: each access is a window (grant g, end e); rdy at e+1,
  // next arbitration allowed from e+2
  int          cyc = 0;
  bit          m_valid = 1'b0;
  bit          m_act = 1'b0;
  bit          m_d = 1'b0;
  bit          m_last_d = 1'b1;
  bit          m_err = 1'b0;
  bit          m_we = 1'b0;
  int          m_g = 0;
  int          m_e = -1;
  int          m_arb = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_irdata = '0;
  logic [31:0] m_drdata = '0;
  logic [31:0] m_res;
  bit          exp_en;
  bit          exp_done;

  always @(negedge clk) begin
    if (m_valid) begin
      exp_en   = m_act && m_e < 0 && cyc > m_g;
      exp_done = m_act && m_e >= 0 && cyc == m_e + 1;
      chkb("m_mem_en", mem_en, exp_en);
      chkb("m_i_rdy", i_rdy, exp_done && !m_d);
      chkb("m_d_rdy", d_rdy, exp_done && m_d);
      if (exp_en) begin
        chk("m_mem_addr", mem_addr, m_addr);
        chkb("m_mem_we", mem_we, m_we);
        chk("m_mem_wdata", mem_wdata, m_wdata);
      end else begin
        chkb("m_mem_we_idle", mem_we, 1'b0);
      end
      chk("m_i_rdata", i_rdata, m_irdata);
      chk("m_d_rdata", d_rdata, m_drdata);
      chkb("m_bus_err", bus_err, m_err);
    end
    if (reset === 1'b0) begin
      m_valid  = 1'b1;
      m_act    = 1'b0;
      m_last_d = 1'b1;
      m_err    = 1'b0;
      m_irdata = '0;
      m_drdata = '0;
      m_arb    = cyc + 1;
    end else if (m_valid) begin
      if (m_act && m_e < 0 && cyc > m_g) begin
        if (mem_ack === 1'b1 || cyc - m_g == TO) begin
          m_e   = cyc;
          m_res = (mem_ack === 1'b1) ? mem_rdata : 32'hDEADBEEF;
          if (mem_ack !== 1'b1) m_err = 1'b1;
          if (m_d) m_drdata = m_res;
          else m_irdata = m_res;
        end
      end else if (m_act && m_e >= 0 && cyc == m_e + 1) begin
        m_act = 1'b0;
        m_arb = cyc + 1;
      end else if (!m_act && cyc >= m_arb && (i_req || d_req)) begin
        if (i_req && d_req) begin
          m_d      = !m_last_d;
          m_last_d = m_d;
        end else begin
          m_d = d_req;
        end
        m_act   = 1'b1;
        m_g     = cyc;
        m_e     = -1;
        m_addr  = m_d ? d_addr : i_addr;
        m_we    = m_d ? d_we : 1'b0;
        m_wdata = m_d ? d_wdata : 32'h0;
      end
    end
    cyc++;
  end

  task automatic run_req(input bit is_d, input int n,
                         input logic [31:0] base);
    bit got;
    for (int k = 0; k < n; k++) begin
      if (is_d) begin
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = base + 32'(k * 4);
      end else begin
        i_req  = 1'b1;
        i_addr = base + 32'(k * 4);
      end
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        tick();
        got = is_d ? d_rdy : i_rdy;
      end
      chkb(is_d ? "d_req_done" : "i_req_done", got, 1'b1);
      if (is_d) d_req = 1'b0;
      else i_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit reached");
  end

  initial begin
    int cnt;
    int rdy_n;
    int irdy_n;
    int bad;
    bit got;
    reset   = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (2) tick();
    chkb("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chkb("rst_bus_err", bus_err, 1'b0);
    reset = 1'b1;
    tick();

    ack_k  = 1;
    i_req  = 1'b1;
    i_addr = 32'h100;
    tick();
    chkb("fx_mem_en", mem_en, 1'b1);
    chk("fx_mem_addr", mem_addr, 32'h100);
    chkb("fx_mem_we", mem_we, 1'b0);
    tick();
    chkb("fx_i_rdy", i_rdy, 1'b1);
    chk("fx_i_rdata", i_rdata, 32'h8C010004);
    i_req = 1'b0;
    tick();
    chkb("fx_i_rdy_drop", i_rdy, 1'b0);

    ack_k   = 3;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'h55;
    cnt = 0; rdy_n = 0; irdy_n = 0; bad = 0;
    repeat (10) begin
      tick();
      if (mem_en && mem_we) begin
        cnt++;
        if (mem_wdata !== 32'h55 || mem_addr !== 32'h20) bad++;
      end
      if (d_rdy) begin
        rdy_n++;
        d_req = 1'b0;
        d_we  = 1'b0;
      end
      if (i_rdy) irdy_n++;
    end
    chk("sb_we_cycles", 32'(cnt), 32'd3);
    chk("sb_wdata_bad", 32'(bad), 32'd0);
    chk("sb_d_rdy_pulses", 32'(rdy_n), 32'd1);
    chk("sb_i_rdy_pulses", 32'(irdy_n), 32'd0);

    spur = 1'b1;
    repeat (2) tick();
    spur = 1'b0;
    repeat (3) tick();
    chk("spur_i_rdata", i_rdata, 32'h8C010004);
    chkb("spur_d_rdy", d_rdy, 1'b0);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    glog.delete();
    ack_k = 2;
    fork
      run_req(1'b0, 4, 32'h1000);
      run_req(1'b1, 4, 32'h2000);
    join
    chk("tie_grants", 32'(glog.size()), 32'd8);
    for (int k = 0; k < 8 && k < glog.size(); k++)
      chkb("tie_order", glog[k], k[0]);

    ack_k   = 0;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h40;
    cnt = 0;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      if (mem_en) cnt++;
      if (d_rdy) got = 1'b1;
    end
    d_req = 1'b0;
    chkb("to_done", got, 1'b1);
    chk("to_en_cycles", 32'(cnt), 32'd16);
    chk("to_d_rdata", d_rdata, 32'hDEADBEEF);
    chkb("to_bus_err", bus_err, 1'b1);
    tick();
    ack_k = 1;
    run_req(1'b0, 1, 32'h104);
    chk("to_after_i_rdata", i_rdata, 32'hC0DE0104);
    chkb("to_err_sticky", bus_err, 1'b1);

    ack_k  = 0;
    d_req  = 1'b1;
    d_addr = 32'h60;
    repeat (4) tick();
    chkb("rb_mem_en_busy", mem_en, 1'b1);
    reset = 1'b0;
    d_req = 1'b0;
    tick();
    chkb("rb_mem_en", mem_en, 1'b0);
    chkb("rb_bus_err", bus_err, 1'b0);
    reset = 1'b1;
    rdy_n = 0;
    repeat (3) begin
      tick();
      if (d_rdy || i_rdy) rdy_n++;
    end
    chk("rb_no_rdy", 32'(rdy_n), 32'd0);
    glog.delete();
    ack_k = 1;
    fork
      run_req(1'b0, 1, 32'h1100);
      run_req(1'b1, 1, 32'h2100);
    join
    chk("rb_tie_grants", 32'(glog.size()), 32'd2);
    if (glog.size() > 0) chkb("rb_tie_first_i", glog[0], 1'b0);

    ack_k  = TO;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h80;
    cnt = 0;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      if (mem_en) cnt++;
      if (d_rdy) got = 1'b1;
    end
    d_req = 1'b0;
    chkb("co_done", got, 1'b1);
    chk("co_en_cycles", 32'(cnt), 32'd16);
    chk("co_d_rdata", d_rdata, 32'hC0DE0080);
    chkb("co_bus_err", bus_err, 1'b0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between two requesters of the multicycle MIPS core.
- Requester I is the instruction-fetch path (FX state). Requester D is the data path (LB/SB states).
- Owns the memory strobes, arbitrates round-robin, and waits a variable number of cycles for memory acknowledge.
- A per-access timeout prevents a dead memory from hanging the controller.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles mem_en may stay high without mem_ack before abort (legal range 2..255)
- ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out access

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-low reset (reset==0 at posedge resets)
- i_req  in  1  instruction fetch request; held until i_rdy
- i_addr  in  AW  fetch address; stable while i_req
- i_rdy  out  1  one-cycle pulse: fetch complete, i_rdata valid this cycle
- i_rdata  out  DW  fetched word
- d_req  in  1  data request; held until d_rdy
- d_we  in  1  1=store (SB), 0=load (LB); stable while d_req
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdy  out  1  one-cycle pulse: data access complete
- d_rdata  out  DW  load data, valid with d_rdy
- mem_en  out  1  memory access strobe, held until mem_ack
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle, only meaningful while mem_en=1
- bus_err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset: state=IDLE; all outputs 0 (i_rdata, d_rdata, mem_addr, mem_wdata all 0); last_grant=D, so the first tie goes to I; timeout counter=0.
- All outputs are registered.

State IDLE:
- If exactly one req is high, grant it.
- If both are high, grant the one not equal to last_grant, then update last_grant.
- On grant, next cycle enter BUSY with mem_en=1 and mem_addr latched from the winner.
- For D, also latch mem_we=d_we and mem_wdata=d_wdata. For I, mem_we=0 and mem_wdata=0.
- Requester inputs are sampled only at grant; later changes are ignored.

State BUSY:
- mem_en, mem_we, mem_addr and mem_wdata are held constant; the counter increments each cycle.
- mem_ack=1: latch mem_rdata into the winner's rdata register (stores also latch it, value don't-care). Next cycle enter RESP with the winner's rdy=1 and mem_en=0, mem_we=0.
- Counter reaches TIMEOUT with no ack: latch ERR_DATA as the winner's rdata and set bus_err=1. Next cycle enter RESP as above.
- If ack and timeout occur in the same cycle, ack wins: normal data, bus_err unchanged.

State RESP:
- Lasts 1 cycle with rdy=1, then returns to IDLE and rdy drops to 0.
- RESP exists so the requester can drop req before the next arbitration; req is not sampled in RESP.
- The loser of a tie keeps its req high and is granted in the following IDLE cycle.

Timing:
- Minimum latency: req at cycle N → mem_en at N+1 → ack at N+1 → rdy at N+2 → IDLE at N+3 → next mem_en at N+4.
- rdata registers hold their value until the next completion for the same requester.
- mem_ack outside BUSY is ignored.
- At most one mem_en is outstanding at any time.
- Reset asserted in any state returns to IDLE within one cycle: mem_en drops, rdy is not issued for the aborted access, bus_err is cleared.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, mem_ack 1 cycle after mem_en with mem_rdata=0x8C010004 → mem_en/mem_addr=0x100 at N+1, i_rdy pulse at N+2 with i_rdata=0x8C010004, mem_we never 1.
- Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x55, ack after 3 cycles → mem_we=1, mem_wdata=0x55 held 3 cycles, single d_rdy pulse, i_rdy stays 0.
- Tie fairness: i_req and d_req high together from reset, 4 back-to-back accesses each → grant order I,D,I,D,…; each rdy is a 1-cycle pulse; no two mem_en windows overlap.
- Timeout: d_req load, mem_ack never asserted, TIMEOUT=16 → mem_en high exactly 16 cycles, d_rdy with d_rdata=0xDEADBEEF, bus_err=1 and stays 1 through later good accesses.
- Ack coincident with timeout on cycle 16 → normal mem_rdata returned, bus_err=0.
- Reset mid-BUSY: reset=0 while mem_en=1 → next cycle mem_en=0, no rdy pulse, bus_err=0, and the next tie is granted to I.
